// File: rtl/mt_thread_sched.sv
// Per-cycle round-robin thread scheduler for the barrel fetch stage.
// Define MT_SCHED_FIXED_BARREL_EN for fixed barrel slots (non-RUN threads become bubbles).
module mt_thread_sched #(
    parameter int unsigned NUM_THREADS  = 8,
    parameter int unsigned BITS_THREADS = $clog2(NUM_THREADS),
    parameter logic [NUM_THREADS-1:0] RESET_MASK = NUM_THREADS'(1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spawn_en,
    input  logic [BITS_THREADS-1:0] spawn_tid,
    input  logic                    halt_en,
    input  logic [BITS_THREADS-1:0] halt_tid,
    input  logic                    wait_set,
    input  logic [BITS_THREADS-1:0] wait_set_tid,
    input  logic                    wait_clr,
    input  logic [BITS_THREADS-1:0] wait_clr_tid,
    output logic [BITS_THREADS-1:0] tid,
    output logic                    tid_valid,
    output logic [NUM_THREADS-1:0]  run_mask,
    output logic                    all_idle
);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_WAIT = 2'd2
    } thr_state_e;

    thr_state_e              state_q [NUM_THREADS];
    thr_state_e              state_d [NUM_THREADS];
    logic [NUM_THREADS-1:0]  elig;
    logic [NUM_THREADS-1:0]  idle_bits;
    logic [BITS_THREADS-1:0] last_tid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++)
                state_q[i] <= RESET_MASK[i] ? T_RUN : T_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_THREADS; i++)
                state_q[i] <= state_d[i];
        end
    end

    // Next-state: halt beats spawn beats wait_set beats wait_clr
    always_comb begin
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            state_d[i] = state_q[i];
            if (halt_en && halt_tid == BITS_THREADS'(i))
                state_d[i] = T_IDLE;
            else if (spawn_en && spawn_tid == BITS_THREADS'(i) && state_q[i] == T_IDLE)
                state_d[i] = T_RUN;
            else if (wait_set && wait_set_tid == BITS_THREADS'(i) && state_q[i] == T_RUN)
                state_d[i] = T_WAIT;
            else if (wait_clr && wait_clr_tid == BITS_THREADS'(i) && state_q[i] == T_WAIT)
                state_d[i] = T_RUN;
        end
    end

    // Outputs decoded from state
    always_comb begin
        elig      = '0;
        run_mask  = '0;
        idle_bits = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            elig[i]      = (state_d[i] == T_RUN);
            run_mask[i]  = (state_q[i] == T_RUN);
            idle_bits[i] = (state_q[i] == T_IDLE);
        end
        all_idle = &idle_bits;
    end

`ifdef MT_SCHED_FIXED_BARREL_EN
    logic [BITS_THREADS-1:0] slot;

    always_comb begin
        slot = last_tid + BITS_THREADS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_tid  <= BITS_THREADS'(NUM_THREADS - 1);
            tid       <= '0;
            tid_valid <= 1'b0;
        end else begin
            last_tid  <= slot;
            tid       <= slot;
            tid_valid <= elig[slot];
        end
    end
`else
    logic                    pick_found;
    logic [BITS_THREADS-1:0] pick_tid;
    logic [BITS_THREADS-1:0] cand;

    // Offset NUM_THREADS wraps back to last_tid, so it is searched last
    always_comb begin
        pick_found = 1'b0;
        pick_tid   = last_tid;
        cand       = last_tid;
        for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
            cand = last_tid + BITS_THREADS'(k);
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick_tid   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_tid  <= BITS_THREADS'(NUM_THREADS - 1);
            tid       <= '0;
            tid_valid <= 1'b0;
        end else if (pick_found) begin
            last_tid  <= pick_tid;
            tid       <= pick_tid;
            tid_valid <= 1'b1;
        end else begin
            tid_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/mt_thread_sched.md
Name: mt_thread_sched

Overview:
- Per-cycle thread scheduler for the barrel fetch stage.
- Holds a run state for each hardware thread and picks one eligible thread per cycle in round-robin order.
- Drives the tid of the per-thread PC file (mt_pc) together with a valid qualifier.
- Spawn, halt, wait-set and wait-clear events arrive from the decode, execute and memory stages.

Parameters:
- NUM_THREADS, 8, number of hardware threads; must be a power of 2.
- BITS_THREADS, $clog2(NUM_THREADS), width of a thread id.
- RESET_MASK, 1 (NUM_THREADS bits), threads in RUN after reset; all others are IDLE.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- spawn_en  in  1  request to start a thread.
- spawn_tid  in  BITS_THREADS  thread to start.
- halt_en  in  1  request to stop a thread (ecall/ebreak at execute).
- halt_tid  in  BITS_THREADS  thread to stop.
- wait_set  in  1  request to park a thread (long-latency memory op).
- wait_set_tid  in  BITS_THREADS  thread to park.
- wait_clr  in  1  request to release a parked thread.
- wait_clr_tid  in  BITS_THREADS  thread to release.
- tid  out  BITS_THREADS  thread selected for fetch this cycle.
- tid_valid  out  1  tid is a real issue slot; 0 means bubble.
- run_mask  out  NUM_THREADS  bit i = thread i in RUN.
- all_idle  out  1  every thread is IDLE.

Behaviour:
- Per-thread state: IDLE, RUN or WAIT.
- Transitions per thread i, evaluated every cycle, highest priority first:
  - halt_en and halt_tid==i: any state -> IDLE.
  - spawn_en and spawn_tid==i and state==IDLE: -> RUN. Spawn on RUN or WAIT is ignored.
  - wait_set and wait_set_tid==i and state==RUN: -> WAIT.
  - wait_clr and wait_clr_tid==i and state==WAIT: -> RUN.
  - wait_set and wait_clr on the same RUN thread in the same cycle: wait_clr ignored, thread -> WAIT.
  - Events aimed at different threads in the same cycle all apply independently.
- Eligibility: thread i is eligible if its next-state is RUN. A thread halted or parked in cycle n is therefore never presented in cycle n+1, and a thread spawned in cycle n may be presented in cycle n+1.
- Selection, registered, 1-cycle latency:
  - Internal pointer last_tid.
  - Search order: last_tid+1, last_tid+2, ... wrapping modulo NUM_THREADS, ending with last_tid itself.
  - First eligible thread found: tid<=it, tid_valid<=1, last_tid<=it.
  - None eligible: tid_valid<=0, tid holds its value, last_tid unchanged.
- With a single eligible thread, that thread issues every cycle.
- run_mask and all_idle are decoded combinationally from the current state registers.
- Reset, synchronous, dominates all events in the same cycle:
  - state = RUN for each bit set in RESET_MASK, else IDLE.
  - last_tid = NUM_THREADS-1, so thread 0 is searched first.
  - tid = 0, tid_valid = 0.
- Reset asserted mid-operation discards all pending states; the first valid slot is 1 cycle after rst deasserts.
- Out-of-range tids cannot occur because NUM_THREADS is a power of 2.

Optional Feature:
- Macro: MT_SCHED_FIXED_BARREL_EN.
- Defined (fixed barrel mode):
  - The selection rule is replaced; every cycle out of reset, tid<=last_tid+1 (wrapping) and last_tid advances unconditionally.
  - tid_valid<=eligibility of that thread, so non-RUN threads become bubble slots and the slot pattern is fixed.
  - The state machine, reset values, run_mask and all_idle are unchanged.
- Not defined: round-robin skipping as above.

Test Plan:
1. Reset with RESET_MASK=1, then release rst, no events -> from the 1st cycle after release, tid=0 and tid_valid=1 every cycle; run_mask=8'h01; all_idle=0.
2. spawn_en with spawn_tid=3 at cycle n -> run_mask=8'h09 from n+1; tid alternates 3,0,3,0 starting n+1.
3. Threads 0..7 all RUN, wait_set with wait_set_tid=5 while tid=4 -> next tid=6; 5 absent. wait_clr with wait_clr_tid=5 later -> 5 reappears within 8 cycles.
4. halt_en and spawn_en both targeting tid=2 in the same cycle while thread 2 is IDLE -> thread 2 stays IDLE. halt_en targeting thread 0 as the only RUN thread -> tid_valid=0 next cycle, all_idle=1, tid holds 0.
5. wait_set and wait_clr both targeting tid=1 in the same cycle, thread 1 RUN -> thread 1 in WAIT; never issued until a later wait_clr.
6. MT_SCHED_FIXED_BARREL_EN defined, run_mask=8'h05 -> tid sequence 0,1,2,...,7,0 with tid_valid=1,0,1,0,0,0,0,0.
